// File: rtl/sea_round_seq.sv
// Iterative sequencer for the SEA Feistel round: loads a block and key, drives an
// external combinational round for ROUNDS cycles, then holds the result on a valid/ready port.
module sea_round_seq #(
    parameter int ROUNDS = 16,
    parameter int KROT   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_dec,
    input  logic [95:0] in_data,
    input  logic [95:0] in_key,
    output logic [47:0] rnd_nli,
    output logic [47:0] rnd_nri,
    output logic [47:0] rnd_ki,
    input  logic [47:0] rnd_li,
    input  logic [47:0] rnd_ri,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_data,
    output logic        busy,
    output logic [4:0]  round_idx
);

    // Rotation amounts are elaboration-time constants, so the key path is pure wiring.
    localparam int         STEP = KROT % 96;
    localparam int         PRE  = (KROT * (ROUNDS - 1)) % 96;
    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e      state_q, state_d;
    logic [47:0] l_q, l_d;
    logic [47:0] r_q, r_d;
    logic [95:0] kr_q, kr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;

    function automatic logic [95:0] rotl(input logic [95:0] x, input int n);
        logic [191:0] t;
        t = {x, x} << n;
        return t[191:96];
    endfunction

    always_comb begin
        // NOTE: every next-state signal defaults to its held value so no path infers a latch.
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        kr_d    = kr_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l_d     = in_data[95:48];
                        r_d     = in_data[47:0];
                        cnt_d   = 5'd0;
                        dec_d   = in_dec;
                        kr_d    = in_dec ? rotl(in_key, PRE) : in_key;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    l_d  = rnd_li;
                    r_d  = rnd_ri;
                    kr_d = dec_q ? rotl(kr_q, (96 - STEP) % 96) : rotl(kr_q, STEP);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            kr_q    <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            kr_q    <= kr_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

    assign rnd_nli   = l_q;
    assign rnd_nri   = r_q;
    assign rnd_ki    = kr_q[95:48];
    assign out_data  = {l_q, r_q};
    assign round_idx = cnt_q;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sea_round_seq.sv
// Scoreboard bench for sea_round_seq: a stub round (li = nli ^ ki, ri = nri) and a
// reference model that derives every round key directly from the master key.
module tb_sea_round_seq;

    localparam int KROT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_dec = 1'b0;
    logic [95:0] in_data = '0;
    logic [95:0] in_key = '0;
    logic [47:0] rnd_nli, rnd_nri, rnd_ki, rnd_li, rnd_ri;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [95:0] out_data;
    logic        busy;
    logic [4:0]  round_idx;

    logic        u1_in_valid = 1'b0;
    logic        u1_in_ready;
    logic        u1_in_dec = 1'b0;
    logic [95:0] u1_in_data = '0;
    logic [95:0] u1_in_key = '0;
    logic [47:0] u1_nli, u1_nri, u1_ki, u1_li, u1_ri;
    logic        u1_out_valid;
    logic        u1_out_ready = 1'b1;
    logic [95:0] u1_out_data;
    logic        u1_busy;
    logic [4:0]  u1_round_idx;

    always #5 clk = ~clk;

    assign rnd_li = rnd_nli ^ rnd_ki;
    assign rnd_ri = rnd_nri;
    assign u1_li  = u1_nli ^ u1_ki;
    assign u1_ri  = u1_nri;

    sea_round_seq #(.ROUNDS(16), .KROT(KROT)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
        .in_data(in_data), .in_key(in_key),
        .rnd_nli(rnd_nli), .rnd_nri(rnd_nri), .rnd_ki(rnd_ki),
        .rnd_li(rnd_li), .rnd_ri(rnd_ri),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round_idx(round_idx)
    );

    sea_round_seq #(.ROUNDS(1), .KROT(KROT)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .in_valid(u1_in_valid), .in_ready(u1_in_ready), .in_dec(u1_in_dec),
        .in_data(u1_in_data), .in_key(u1_in_key),
        .rnd_nli(u1_nli), .rnd_nri(u1_nri), .rnd_ki(u1_ki),
        .rnd_li(u1_li), .rnd_ri(u1_ri),
        .out_valid(u1_out_valid), .out_ready(u1_out_ready), .out_data(u1_out_data),
        .busy(u1_busy), .round_idx(u1_round_idx)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Encrypt round e uses the master key rotated left by KROT*e; decrypt reverses the order.
    function automatic logic [47:0] key_at(input logic [95:0] k, input bit dec,
                                           input int j, input int rounds);
        int e;
        logic [191:0] t;
        e = dec ? rounds - 1 - j : j;
        t = {k, k} << ((KROT * e) % 96);
        return t[191:144];
    endfunction

    function automatic logic [95:0] model(input logic [95:0] d, input logic [95:0] k,
                                          input bit dec, input int rounds);
        logic [47:0] l;
        l = d[95:48];
        for (int j = 0; j < rounds; j++) l = l ^ key_at(k, dec, j, rounds);
        return {l, d[47:0]};
    endfunction

    logic [95:0] exp_q[$];
    logic [95:0] cur_key;
    bit          cur_dec;
    bit          in_run = 1'b0;
    bit          done_seen = 1'b0;
    int          rc = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          prev_acc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (in_run && busy && !out_valid) begin
                check("round_idx", 96'(round_idx), 96'(rc));
                check("round_key", 96'(rnd_ki), 96'(key_at(cur_key, cur_dec, rc, 16)));
                rc++;
            end
            if (in_run && out_valid && !done_seen) begin
                done_seen = 1'b1;
                check("run_edges", 96'(rc), 96'd16);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                in_run = 1'b0;
            end
            if (in_valid && in_ready && !clr) begin
                exp_q.push_back(model(in_data, in_key, in_dec, 16));
                cur_key   = in_key;
                cur_dec   = in_dec;
                rc        = 0;
                in_run    = 1'b1;
                done_seen = 1'b0;
                prev_acc  = last_acc;
                last_acc  = cyc;
            end
        end
    end

    bit rand_mode = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [95:0] d, input logic [95:0] k, input bit dec);
        bit acc;
        acc = 1'b0;
        in_data  = d;
        in_key   = k;
        in_dec   = dec;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
    endtask

    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL out_timeout: out_valid never rose");
        end
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 96'(in_ready), 96'd1);
        check({tag, "_out_valid"}, 96'(out_valid), 96'd0);
        check({tag, "_busy"}, 96'(busy), 96'd0);
        check({tag, "_out_data"}, out_data, 96'd0);
        check({tag, "_rnd"}, {rnd_nli, rnd_nri}, 96'd0);
        check({tag, "_ki_idx"}, {43'd0, rnd_ki, round_idx}, 96'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] snap, d1, k1;
        int max_ov;

        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Encrypt key schedule with a single set bit.
        send(96'd0, 96'd1 << 50, 1'b0);
        in_valid = 1'b0;
        @(negedge clk) check("enc_k0", 96'(rnd_ki), 96'h4);
        @(negedge clk) check("enc_k1", 96'(rnd_ki), 96'h20);
        repeat (14) @(negedge clk);
        check("enc_k15", 96'(rnd_ki), 96'h8000_0000_0000);
        @(negedge clk) check("enc_done", 96'(out_valid), 96'd1);

        // Same key, decrypt order.
        send(96'd0, 96'd1 << 50, 1'b1);
        in_valid = 1'b0;
        @(negedge clk) check("dec_k0", 96'(rnd_ki), 96'h8000_0000_0000);
        @(negedge clk) check("dec_k1", 96'(rnd_ki), 96'h1000_0000_0000);
        repeat (14) @(negedge clk);
        check("dec_k15", 96'(rnd_ki), 96'h4);
        drain();

        // Backpressure on the result port.
        out_ready = 1'b0;
        send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b0);
        in_valid = 1'b0;
        wait_out();
        snap = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 96'(out_valid), 96'd1);
            check("bp_data", out_data, snap);
            check("bp_in_ready", 96'(in_ready), 96'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk) check("bp_in_ready_pre", 96'(in_ready), 96'd0);
        @(negedge clk) check("bp_in_ready_post", 96'(in_ready), 96'd1);

        // Back-to-back blocks with in_valid held high.
        send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b0);
        send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b1);
        in_valid = 1'b0;
        check("b2b_interval", 96'(last_acc - prev_acc), 96'd18);
        drain();

        // Synchronous abort at round 7.
        send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b0);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("clr_round", 96'(round_idx), 96'd7);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        in_run = 1'b0;
        if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        @(negedge clk);
        check("clr_in_ready", 96'(in_ready), 96'd1);
        check("clr_busy", 96'(busy), 96'd0);
        check("clr_idx", 96'(round_idx), 96'd0);
        max_ov = 0;
        repeat (20) @(negedge clk) if (out_valid) max_ov = 1;
        check("clr_no_output", 96'(max_ov), 96'd0);

        // Asynchronous reset mid-RUN.
        send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b1);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        in_run = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk) check("post_rst_busy", 96'(busy), 96'd0);

        // Randomized traffic with random backpressure.
        rand_mode = 1'b1;
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)));
            in_valid = 1'b0;
        end
        drain();
        rand_mode = 1'b0;
        out_ready = 1'b1;

        // Single-round instance: decrypt has no pre-rotation.
        d1 = {$urandom, $urandom, $urandom};
        tick();
        u1_in_valid = 1'b1;
        u1_in_data  = d1;
        u1_in_key   = 96'h1;
        u1_in_dec   = 1'b1;
        @(negedge clk) check("r1_in_ready", 96'(u1_in_ready), 96'd1);
        tick();
        u1_in_valid = 1'b0;
        @(negedge clk);
        check("r1_dec_ki", 96'(u1_ki), 96'h0);
        check("r1_busy", 96'(u1_busy), 96'd1);
        check("r1_not_done", 96'(u1_out_valid), 96'd0);
        @(negedge clk);
        check("r1_dec_valid", 96'(u1_out_valid), 96'd1);
        check("r1_dec_data", u1_out_data, model(d1, 96'h1, 1'b1, 1));

        d1 = {$urandom, $urandom, $urandom};
        k1 = {$urandom, $urandom, $urandom};
        tick();
        u1_in_valid = 1'b1;
        u1_in_data  = d1;
        u1_in_key   = k1;
        u1_in_dec   = 1'b0;
        tick();
        u1_in_valid = 1'b0;
        @(negedge clk) check("r1_enc_ki", 96'(u1_ki), 96'(k1[95:48]));
        @(negedge clk) check("r1_enc_data", u1_out_data, model(d1, k1, 1'b0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sea_round_seq.md
Name: sea_round_seq

Overview:
- Iterative sequencer for the 48-bit-half SEA Feistel round datapath (sbox layer, rotate, xor, half-swap).
- Accepts a 96-bit block and a 96-bit master key over a valid/ready handshake.
- Drives one external combinational round instance for ROUNDS cycles, generates the per-round 48-bit key (forward order for encrypt, reverse order for decrypt), and presents the result on a valid/ready output.

Parameters:
- ROUNDS, 16, rounds per block; legal range 1..32.
- KROT, 3, key-register rotation per round in bits (one sbox width); legal range 1..95.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  input block/key valid.
- in_ready  out  1  block can accept an input.
- in_dec  in  1  1 = decrypt key order, 0 = encrypt key order.
- in_data  in  96  {L[47:0], R[47:0]}.
- in_key  in  96  master key.
- rnd_nli  out  48  to round datapath nli.
- rnd_nri  out  48  to round datapath nri.
- rnd_ki  out  48  to round datapath ki.
- rnd_li  in  48  from round datapath li.
- rnd_ri  in  48  from round datapath ri.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  96  {L, R} after the final round.
- busy  out  1  high in RUN or DONE.
- round_idx  out  5  current round number, 0..ROUNDS-1.

Behaviour:

Registers:
- state: IDLE / RUN / DONE.
- L, R: 48 bits each.
- kr: 96 bits.
- cnt: 5 bits.

Reset (rst_n low, async):
- state=IDLE; L, R, kr, cnt = 0.
- Outputs: in_ready=1, out_valid=0, busy=0, out_data=0, rnd_*=0, round_idx=0.

Combinational outputs:
- rnd_nli=L, rnd_nri=R, rnd_ki=kr[95:48].
- out_data={L,R}, round_idx=cnt.
- in_ready = (state==IDLE).
- out_valid = (state==DONE).
- busy = (state!=IDLE).

IDLE:
- On in_valid & in_ready: L=in_data[95:48], R=in_data[47:0], cnt=0, state=RUN.
- Encrypt (in_dec=0): kr = in_key.
- Decrypt (in_dec=1): kr = rotl(in_key, (KROT*(ROUNDS-1)) mod 96).
- A decrypt round j therefore uses the key of encrypt round ROUNDS-1-j.

RUN:
- Every edge: L=rnd_li, R=rnd_ri.
- Key update: kr = rotl(kr,KROT) for encrypt, rotr(kr,KROT) for decrypt. The direction flag is latched at accept; in_dec is ignored after accept.
- If cnt==ROUNDS-1: state=DONE, cnt held. Otherwise cnt=cnt+1.
- Exactly ROUNDS round evaluations per block.

DONE:
- L, R, kr frozen; out_valid held high until out_ready is sampled high.
- On out_valid & out_ready: state=IDLE.
- A new input cannot be accepted in the same cycle; in_ready rises the cycle after.

Latency and throughput:
- Accept at edge E0 → out_valid high after edge E0+ROUNDS.
- Minimum initiation interval is ROUNDS+2 cycles.

Boundary conditions:
- ROUNDS=1: RUN lasts one cycle; the decrypt pre-rotation is 0.
- in_valid held high while busy is ignored; in_data may change freely.
- out_ready high before DONE has no effect.
- clr has priority over every transition in every state: state=IDLE, cnt=0; L/R/kr keep their values. clr is harmless in IDLE.
- rst_n asserted mid-RUN or mid-DONE: immediate return to the reset values; no output is produced for the aborted block.
- Rotation amounts are taken mod 96 and computed at elaboration; there is no runtime multiplier.

Test Plan:
- Bench model: stub round with li=nli^ki, ri=nri.
  Stimulus: ROUNDS=16, KROT=3, encrypt, in_key=1<<50, in_data=0.
  Required: rnd_ki is 48'h4 in round 0, 48'h20 in round 1; round 15 key is 48'h8000_0000_0000; out_valid after exactly 16 RUN edges.
- Same key, decrypt:
  Required: round 0 key is 48'h8000_0000_0000, round 1 key is 48'h1000_0000_0000, round 15 key is 48'h4.
- Backpressure: out_ready=0 for 5 cycles after DONE.
  Required: out_valid and out_data stable; in_ready=0 throughout; in_ready=1 exactly one cycle after out_ready=1.
- Back-to-back: in_valid held high with two blocks.
  Required: second block accepted ROUNDS+2 cycles after the first; no block dropped or duplicated.
- clr asserted at round 7.
  Required: next cycle state=IDLE, in_ready=1, out_valid never rises.
  Then rst_n pulsed mid-RUN: all outputs return to reset values asynchronously.
- ROUNDS=1, decrypt, in_key=96'h1.
  Required: rnd_ki=48'h0 (in_key[95:48], no pre-rotation); out_valid one edge after accept.
